// File: rtl/spi_slave_shifter.sv
// SPI slave byte shifter: synchronizes the SPI pins and exchanges one byte per frame with single-byte tx/rx holding registers.
// Latency: pin edges act SYNC_STAGES+1 pclk cycles after they occur; a received byte lands in rx_data_o one cycle after its last sample edge.
// Backpressure: none; tx writes are dropped while tx_buf is occupied, and a byte arriving while rx_full_o=1 is dropped with overrun_o set.
// Optional LSB-first support is compiled in with macro SPI_SLAVE_LSBFE_EN.
module spi_slave_shifter #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       pclk,
    input  logic       preset,
    input  logic       spi_en_i,
    input  logic       cpol_i,
    input  logic       cpha_i,
    input  logic       lsbfe_i,
    input  logic       sclk_i,
    input  logic       ss_i,
    input  logic       mosi_i,
    output logic       miso_o,
    output logic       miso_oe_o,
    input  logic [7:0] tx_data_i,
    input  logic       tx_wr_i,
    output logic       tx_empty_o,
    output logic [7:0] rx_data_o,
    output logic       rx_full_o,
    input  logic       rx_rd_i,
    output logic       overrun_o,
    output logic       busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_d;
    logic                   ss_d;
    logic                   mosi_d;
    logic [2:0]             bit_cnt;
    logic [7:0]             tx_buf;
    logic [7:0]             tx_sr;
    logic [7:0]             rx_sr;
    logic                   lsb_first;

`ifdef SPI_SLAVE_LSBFE_EN
    assign lsb_first = lsbfe_i;
`else
    logic unused_lsbfe;
    assign unused_lsbfe = lsbfe_i;
    assign lsb_first    = 1'b0;
`endif

    // Next bit to drive sits at the head of tx_sr; advancing drops it.
    function automatic logic head_bit(input logic [7:0] v, input logic lsb);
        return lsb ? v[0] : v[7];
    endfunction

    function automatic logic [7:0] advance(input logic [7:0] v, input logic lsb);
        return lsb ? {1'b0, v[7:1]} : {v[6:0], 1'b0};
    endfunction

    logic       sclk_s, ss_s;
    logic       sclk_rise, sclk_fall, ss_fall, ss_rise;
    logic       lead_edge, trail_edge, sample_edge, drive_edge;
    logic [7:0] load_byte, load_sr, rx_next;
    logic       do_load;

    assign sclk_s      = sclk_sync[SYNC_STAGES-1];
    assign ss_s        = ss_sync[SYNC_STAGES-1];
    assign sclk_rise   = sclk_s & ~sclk_d;
    assign sclk_fall   = ~sclk_s & sclk_d;
    assign ss_fall     = ~ss_s & ss_d;
    assign ss_rise     = ss_s & ~ss_d;
    assign lead_edge   = cpol_i ? sclk_fall : sclk_rise;
    assign trail_edge  = cpol_i ? sclk_rise : sclk_fall;
    assign sample_edge = cpha_i ? trail_edge : lead_edge;
    assign drive_edge  = cpha_i ? lead_edge : trail_edge;
    // An empty holding buffer transmits all ones.
    assign load_byte   = tx_empty_o ? 8'hFF : tx_buf;
    // With cpha=0 the first bit goes out at load time, so the shifter keeps only the rest.
    assign load_sr     = cpha_i ? load_byte : advance(load_byte, lsb_first);
    assign rx_next     = lsb_first ? {mosi_d, rx_sr[7:1]} : {rx_sr[6:0], mosi_d};
    assign do_load     = spi_en_i && (((state == ST_IDLE) && ss_fall) || (state == ST_DONE));

    // Pin synchronizers plus one edge-detect stage per pin.
    always_ff @(posedge pclk) begin
        if (preset) begin
            sclk_sync <= '1;
            ss_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b1;
            ss_d      <= 1'b1;
            mosi_d    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_i};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
            sclk_d    <= sclk_s;
            ss_d      <= ss_s;
            mosi_d    <= mosi_sync[SYNC_STAGES-1];
        end
    end

    // Frame FSM with registered outputs, plus tx/rx holding-register bookkeeping.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state      <= ST_IDLE;
            miso_o     <= 1'b0;
            miso_oe_o  <= 1'b0;
            busy_o     <= 1'b0;
            bit_cnt    <= 3'd0;
            tx_sr      <= 8'h00;
            rx_sr      <= 8'h00;
            tx_buf     <= 8'h00;
            tx_empty_o <= 1'b1;
            rx_data_o  <= 8'h00;
            rx_full_o  <= 1'b0;
            overrun_o  <= 1'b0;
        end else begin
            if (!spi_en_i) begin
                state     <= ST_IDLE;
                busy_o    <= 1'b0;
                miso_oe_o <= 1'b0;
                miso_o    <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (ss_fall) begin
                            state     <= ST_SHIFT;
                            busy_o    <= 1'b1;
                            bit_cnt   <= 3'd0;
                            miso_oe_o <= 1'b1;
                            tx_sr     <= load_sr;
                            miso_o    <= cpha_i ? 1'b0 : head_bit(load_byte, lsb_first);
                        end
                    end
                    ST_SHIFT: begin
                        if (ss_rise) begin
                            state     <= ST_IDLE;
                            busy_o    <= 1'b0;
                            miso_oe_o <= 1'b0;
                            miso_o    <= 1'b0;
                        end else if (sample_edge) begin
                            rx_sr   <= rx_next;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                state <= ST_DONE;
                            end
                        end else if (drive_edge && (cpha_i || (bit_cnt != 3'd0))) begin
                            // cpha=0: the trailing edge after the last sample belongs to the
                            // previous byte (bit_cnt wrapped to 0), so it must not shift.
                            miso_o <= head_bit(tx_sr, lsb_first);
                            tx_sr  <= advance(tx_sr, lsb_first);
                        end
                    end
                    ST_DONE: begin
                        bit_cnt <= 3'd0;
                        tx_sr   <= load_sr;
                        if (!cpha_i) begin
                            miso_o <= head_bit(load_byte, lsb_first);
                        end
                        if (ss_s) begin
                            state     <= ST_IDLE;
                            busy_o    <= 1'b0;
                            miso_oe_o <= 1'b0;
                            miso_o    <= 1'b0;
                        end else begin
                            state <= ST_SHIFT;
                        end
                    end
                    default: begin
                        state     <= ST_IDLE;
                        busy_o    <= 1'b0;
                        miso_oe_o <= 1'b0;
                        miso_o    <= 1'b0;
                    end
                endcase
            end

            // Receive holding register: a read in the same cycle frees room for the new byte.
            if (spi_en_i && (state == ST_DONE)) begin
                if (!rx_full_o || rx_rd_i) begin
                    rx_data_o <= rx_sr;
                    rx_full_o <= 1'b1;
                    if (rx_rd_i) begin
                        overrun_o <= 1'b0;
                    end
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (rx_rd_i) begin
                rx_full_o <= 1'b0;
                overrun_o <= 1'b0;
            end

            // Transmit holding register: a load frees it, a write into a free buffer fills it.
            if (do_load) begin
                tx_empty_o <= 1'b1;
            end
            if (tx_wr_i && tx_empty_o) begin
                tx_buf     <= tx_data_i;
                tx_empty_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_shifter.sv
// Bench for spi_slave_shifter: a bit-banged SPI master drives the pins while a byte-level model predicts both directions.
// Latency: master half-period is 8 pclk, well above the synchronizer delay.
// Backpressure: none; the model tracks tx/rx holding-register occupancy and overrun.
module tb_spi_slave_shifter;

    localparam int HALF = 8;

    logic       pclk = 1'b0;
    logic       preset = 1'b1;
    logic       spi_en_i = 1'b0;
    logic       cpol_i = 1'b0;
    logic       cpha_i = 1'b0;
    logic       lsbfe_i = 1'b0;
    logic       sclk_i = 1'b0;
    logic       ss_i = 1'b1;
    logic       mosi_i = 1'b0;
    logic [7:0] tx_data_i = 8'h00;
    logic       tx_wr_i = 1'b0;
    logic       rx_rd_i = 1'b0;
    logic       miso_o, miso_oe_o, tx_empty_o, rx_full_o, overrun_o, busy_o;
    logic [7:0] rx_data_o;

    spi_slave_shifter #(.SYNC_STAGES(2)) dut (
        .pclk(pclk), .preset(preset), .spi_en_i(spi_en_i),
        .cpol_i(cpol_i), .cpha_i(cpha_i), .lsbfe_i(lsbfe_i),
        .sclk_i(sclk_i), .ss_i(ss_i), .mosi_i(mosi_i),
        .miso_o(miso_o), .miso_oe_o(miso_oe_o),
        .tx_data_i(tx_data_i), .tx_wr_i(tx_wr_i), .tx_empty_o(tx_empty_o),
        .rx_data_o(rx_data_o), .rx_full_o(rx_full_o), .rx_rd_i(rx_rd_i),
        .overrun_o(overrun_o), .busy_o(busy_o)
    );

    always #5 pclk = ~pclk;

    int total = 0;
    int bad = 0;

    // Byte-level reference model.
    logic       m_tx_full = 1'b0;
    logic [7:0] m_tx_val = 8'h00;
    logic       m_rx_full = 1'b0;
    logic [7:0] m_rx_data = 8'h00;
    logic       m_ovr = 1'b0;
    logic [7:0] exp_q[$];

    task automatic tick(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic eff_lsb();
`ifdef SPI_SLAVE_LSBFE_EN
        return lsbfe_i;
`else
        return 1'b0;
`endif
    endfunction

    // Byte the slave will shift out next: holding buffer if full, else all ones.
    task automatic model_load();
        exp_q.push_back(m_tx_full ? m_tx_val : 8'hFF);
        m_tx_full = 1'b0;
    endtask

    task automatic wr_tx(input logic [7:0] d);
        tx_data_i = d;
        tx_wr_i = 1'b1;
        tick(1);
        tx_wr_i = 1'b0;
        if (!m_tx_full) begin
            m_tx_full = 1'b1;
            m_tx_val = d;
        end
    endtask

    task automatic rd_rx();
        rx_rd_i = 1'b1;
        tick(1);
        rx_rd_i = 1'b0;
        m_rx_full = 1'b0;
        m_ovr = 1'b0;
    endtask

    task automatic set_mode(input logic cpol, input logic cpha);
        cpol_i = cpol;
        cpha_i = cpha;
        sclk_i = cpol;
        tick(6);
    endtask

    task automatic frame_begin();
        ss_i = 1'b0;
        model_load();
    endtask

    task automatic frame_end();
        tick(HALF);
        ss_i = 1'b1;
        tick(8);
        exp_q.delete();
    endtask

    // One byte (or nbits bits) of master activity; checks miso against the model when complete.
    task automatic xfer_byte(input logic [7:0] mb, input int nbits, input bit lat);
        logic       lsb;
        logic [7:0] got;
        logic [7:0] e;
        logic       s0, s1, prev;
        bit         stable;
        int         b;
        lsb = eff_lsb();
        got = 8'h00;
        stable = 1'b1;
        prev = 1'b0;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hFF;
        for (int i = 0; i < nbits; i++) begin
            b = lsb ? i : 7 - i;
            if (!cpha_i) begin
                mosi_i = mb[b];
                tick(HALF);
                s0 = miso_o;
                got[b] = s0;
                if (i == 0) chk("miso_oe_active", miso_oe_o, 8'h1);
                sclk_i = ~sclk_i;
                if (lat && i == 7) begin
                    tick(3);
                    chk("rx_full_before_done", rx_full_o, 8'h0);
                    tick(1);
                    chk("rx_full_after_done", rx_full_o, 8'h1);
                    tick(HALF - 4);
                end else begin
                    tick(HALF);
                end
                s1 = miso_o;
                if (i != 7 && s1 !== s0) stable = 1'b0;
                sclk_i = ~sclk_i;
            end else begin
                tick(HALF);
                if (i > 0) begin
                    s1 = miso_o;
                    if (s1 !== prev) stable = 1'b0;
                end
                sclk_i = ~sclk_i;
                mosi_i = mb[b];
                tick(HALF);
                s0 = miso_o;
                got[b] = s0;
                prev = s0;
                if (i == 0) chk("busy_active", busy_o, 8'h1);
                sclk_i = ~sclk_i;
            end
        end
        if (nbits == 8) begin
            chk("miso_byte", got, e);
            chk("miso_stable", {7'd0, stable}, 8'h1);
            if (!m_rx_full) begin
                m_rx_full = 1'b1;
                m_rx_data = mb;
            end else begin
                m_ovr = 1'b1;
            end
            model_load();
        end
    endtask

    task automatic check_idle(input string pfx);
        chk({pfx, "_rx_full"}, rx_full_o, m_rx_full);
        chk({pfx, "_rx_data"}, rx_data_o, m_rx_data);
        chk({pfx, "_overrun"}, overrun_o, m_ovr);
        chk({pfx, "_tx_empty"}, tx_empty_o, !m_tx_full);
        chk({pfx, "_busy"}, busy_o, 8'h0);
        chk({pfx, "_miso_oe"}, miso_oe_o, 8'h0);
        chk({pfx, "_miso"}, miso_o, 8'h0);
    endtask

    task automatic check_reset(input string pfx);
        chk({pfx, "_miso"}, miso_o, 8'h0);
        chk({pfx, "_miso_oe"}, miso_oe_o, 8'h0);
        chk({pfx, "_tx_empty"}, tx_empty_o, 8'h1);
        chk({pfx, "_rx_data"}, rx_data_o, 8'h00);
        chk({pfx, "_rx_full"}, rx_full_o, 8'h0);
        chk({pfx, "_overrun"}, overrun_o, 8'h0);
        chk({pfx, "_busy"}, busy_o, 8'h0);
    endtask

    task automatic one_frame(input logic [7:0] mb);
        frame_begin();
        xfer_byte(mb, 8, 1'b0);
        frame_end();
    endtask

    initial begin
        logic [1:0] mode;
        int         nb;

        // Reset state.
        tick(3);
        check_reset("reset");
        preset = 1'b0;
        spi_en_i = 1'b1;
        tick(4);

        // Mode 0 MSB first, with rx_full timing.
        set_mode(1'b0, 1'b0);
        wr_tx(8'hA5);
        chk("tx_empty_after_wr", tx_empty_o, 8'h0);
        frame_begin();
        xfer_byte(8'h3C, 8, 1'b1);
        frame_end();
        check_idle("mode0");
        rd_rx();
        chk("rx_full_after_rd", rx_full_o, 8'h0);

        // Modes 1, 2 and 3.
        for (int m = 1; m < 4; m++) begin
            mode = 2'(m);
            set_mode(mode[1], mode[0]);
            wr_tx(8'hC3);
            one_frame(8'h5A);
            check_idle("modeN");
            rd_rx();
        end

        // Two back-to-back bytes without a read: overrun, second byte sends FF.
        set_mode(1'b0, 1'b0);
        wr_tx(8'h96);
        frame_begin();
        xfer_byte(8'h81, 8, 1'b0);
        xfer_byte(8'h7E, 8, 1'b0);
        frame_end();
        check_idle("b2b");
        rd_rx();
        chk("overrun_cleared", overrun_o, 8'h0);

        // Abort after four sclk edges, then a clean frame.
        set_mode(1'b1, 1'b1);
        wr_tx(8'h3E);
        frame_begin();
        xfer_byte(8'hF0, 2, 1'b0);
        frame_end();
        check_idle("abort");
        wr_tx(8'h5C);
        one_frame(8'hE7);
        check_idle("after_abort");
        rd_rx();

        // Second write while the buffer is occupied is dropped; lsbfe request.
        set_mode(1'b0, 1'b0);
        wr_tx(8'h11);
        wr_tx(8'h22);
        one_frame(8'h42);
        check_idle("tx_ignore");
        rd_rx();
        lsbfe_i = 1'b1;
        wr_tx(8'h01);
        one_frame(8'h80);
        check_idle("lsbfe");
        rd_rx();
        lsbfe_i = 1'b0;

        // Reset pulse mid-frame, then a fresh frame.
        wr_tx(8'h77);
        frame_begin();
        xfer_byte(8'hAA, 3, 1'b0);
        preset = 1'b1;
        ss_i = 1'b1;
        sclk_i = cpol_i;
        tick(1);
        check_reset("midreset");
        preset = 1'b0;
        exp_q.delete();
        m_tx_full = 1'b0;
        m_rx_full = 1'b0;
        m_rx_data = 8'h00;
        m_ovr = 1'b0;
        tick(8);
        wr_tx(8'h69);
        one_frame(8'h1D);
        check_idle("post_reset");
        rd_rx();

        // Disabled block ignores ss and keeps miso undriven.
        spi_en_i = 1'b0;
        ss_i = 1'b0;
        tick(8);
        chk("dis_miso_oe", miso_oe_o, 8'h0);
        chk("dis_busy", busy_o, 8'h0);
        ss_i = 1'b1;
        tick(6);
        spi_en_i = 1'b1;
        tick(4);

        // Random frames against the model.
        for (int k = 0; k < 16; k++) begin
            mode = 2'($urandom_range(0, 3));
            set_mode(mode[1], mode[0]);
            lsbfe_i = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) wr_tx(8'($urandom));
            if ($urandom_range(0, 2) == 0) wr_tx(8'($urandom));
            if ($urandom_range(0, 1) == 1) rd_rx();
            nb = $urandom_range(1, 2);
            frame_begin();
            for (int j = 0; j < nb; j++) begin
                xfer_byte(8'($urandom), 8, 1'b0);
            end
            frame_end();
            check_idle("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_slave_shifter.md
SPI_SLAVE_SHIFTER -- requirements
Module: spi_slave_shifter

Interface
REQ-001 Parameter SYNC_STAGES, default 2, sets the synchronizer depth on sclk_i/ss_i/mosi_i; legal values are 2 and 3.
REQ-002 pclk  input  1  system clock; all logic is clocked on its rising edge.
REQ-003 preset  input  1  synchronous, active-high reset.
REQ-004 spi_en_i  input  1  block enable; 0 forces the IDLE state and keeps miso_oe_o at 0.
REQ-005 cpol_i / cpha_i  input  1 each  clock polarity and phase, same meaning as the master side.
REQ-006 lsbfe_i  input  1  1 = LSB first, 0 = MSB first (see REQ-024).
REQ-007 sclk_i / ss_i / mosi_i  input  1 each  asynchronous SPI pins; ss_i is active-low.
REQ-008 miso_o  output  1  serial data out; miso_oe_o  output  1  drive enable for miso_o.
REQ-009 tx_data_i  input  8  byte to transmit; tx_wr_i  input  1  write strobe for tx_data_i.
REQ-010 tx_empty_o  output  1  transmit holding buffer is free.
REQ-011 rx_data_o  output  8  last received byte; rx_full_o  output  1  rx_data_o holds an unread byte.
REQ-012 rx_rd_i  input  1  read strobe; overrun_o  output  1  sticky receive-overrun flag; busy_o  output  1  frame in progress.

Function
REQ-013 Each pin passes through SYNC_STAGES flops plus one edge-detect flop; sclk_i/ss_i edges are acted on (SYNC_STAGES+1) pclk cycles after the pin changes.
REQ-014 The leading sclk edge is rising when cpol_i=0 and falling when cpol_i=1; the trailing edge is the opposite one.
REQ-015 cpha_i=0: mosi_i is sampled on leading edges, and the next bit is driven on trailing edges; cpha_i=1: the next bit is driven on leading edges, and mosi_i is sampled on trailing edges.
REQ-016 The state machine has states IDLE, SHIFT and DONE.
REQ-017 IDLE -> SHIFT on a synchronized ss falling edge with spi_en_i=1; on entry:
- the shift register loads tx_buf if tx_empty_o=0, otherwise 8'hFF;
- tx_empty_o is set to 1;
- bit_cnt is cleared to 0;
- miso_oe_o is set to 1;
- with cpha_i=0, the first bit appears on miso_o in that same cycle.
REQ-018 SHIFT: each sample edge shifts in one bit and increments bit_cnt (3 bits); on the 8th sample the state goes to DONE.
REQ-019 DONE (one cycle):
- if rx_full_o=0: rx_data_o takes the received byte and rx_full_o is set to 1;
- if rx_full_o=1: the received byte is discarded, rx_data_o is unchanged, and overrun_o is set to 1;
- the shift register reloads as in REQ-017;
- the state goes to SHIFT if ss is still low, otherwise to IDLE.
REQ-020 A synchronized ss rising edge in SHIFT aborts the frame:
- return to IDLE;
- the partial byte is discarded;
- no update to rx_full_o or overrun_o.
REQ-021 ss high or spi_en_i=0 drives miso_oe_o=0 and miso_o=0; busy_o=1 exactly in SHIFT and DONE.
REQ-022 tx_wr_i writes tx_data_i into tx_buf and clears tx_empty_o only when tx_empty_o=1; a write while tx_empty_o=0 is ignored. If tx_wr_i coincides with a shifter load from an empty buffer, the shifter gets 8'hFF and the write lands in tx_buf.
REQ-023 rx_rd_i clears rx_full_o and overrun_o; if rx_rd_i coincides with DONE, the new byte is stored, rx_full_o stays 1, and overrun_o is not set.

Configuration
REQ-024 Macro SPI_SLAVE_LSBFE_EN:
- when defined, lsbfe_i=1 selects LSB-first shift and receive, and lsbfe_i=0 selects MSB first;
- when undefined, lsbfe_i is ignored and all frames are MSB first.

Reset
REQ-025 When preset=1 at a pclk edge:
- state goes to IDLE;
- miso_o=0, miso_oe_o=0, tx_empty_o=1, rx_data_o=8'h00, rx_full_o=0, overrun_o=0, busy_o=0;
- bit_cnt=0, tx_buf=8'h00, and all synchronizer flops take 1, except the mosi flops, which take 0.
REQ-026 Reset asserted mid-frame abandons the frame; after release, the next ss falling edge starts a fresh frame.

Verification
REQ-027 Mode 0 (cpol=0, cpha=0), MSB first, tx_buf=8'hA5, master sends 8'h3C at sclk=pclk/16 -> miso carries 8'hA5; rx_data_o=8'h3C; rx_full_o=1 one cycle after the 8th rising edge is synchronized.
REQ-028 Modes 1, 2 and 3 each exchange 8'h5A against 8'hC3 -> correct bytes on both sides; miso changes only on the drive edge of REQ-015.
REQ-029 Two back-to-back bytes with ss held low, no rx_rd_i between them -> the first byte is kept, overrun_o=1, and the second frame's miso is 8'hFF (buffer empty).
REQ-030 ss deasserted after 4 sclk edges -> no rx_full_o, busy_o=0, and the next full frame receives correctly.
REQ-031 tx_wr_i with 8'h11 then 8'h22 before the frame -> miso sends 8'h11 and the 8'h22 write is ignored; with SPI_SLAVE_LSBFE_EN defined and lsbfe_i=1, 8'h01 is sent LSB first.
REQ-032 preset pulse mid-frame -> every output returns to its REQ-025 value in the next cycle.
